// File: rtl/counter_run_ctrl.sv
// Job sequencer owning a WIDTH-bit wrap counter: (num_runs+1) passes; done at start+N*2^WIDTH edges, no backpressure (pause/abort levels).
// AUTO_RESTART_EN: start in DONE launches the next job directly instead of returning to IDLE.
module counter_run_ctrl #(
    parameter int WIDTH  = 2,
    parameter int RUNS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RUNS_W-1:0] num_runs,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic [RUNS_W-1:0] run_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  w_count_nxt;
    logic [RUNS_W-1:0] r_run_idx;
    logic [RUNS_W-1:0] w_run_idx_nxt;
    logic [RUNS_W-1:0] r_runs_q;
    logic [RUNS_W-1:0] w_runs_q_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_run_idx <= '0;
            r_runs_q  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_run_idx <= w_run_idx_nxt;
            r_runs_q  <= w_runs_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_run_idx_nxt = r_run_idx;
        w_runs_q_nxt  = r_runs_q;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_count_nxt   = '0;
                    w_run_idx_nxt = '0;
                    w_runs_q_nxt  = num_runs;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                    w_run_idx_nxt = '0;
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_count != CNT_MAX) begin
                    w_count_nxt = r_count + WIDTH'(1);
                end else if (r_run_idx < r_runs_q) begin
                    w_count_nxt   = '0;
                    w_run_idx_nxt = r_run_idx + RUNS_W'(1);
                end else begin
                    // Last pass finished: run_idx stays on the final pass number.
                    w_state_nxt = S_DONE;
                    w_count_nxt = '0;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                    w_run_idx_nxt = '0;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
`ifdef AUTO_RESTART_EN
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_count_nxt   = '0;
                    w_run_idx_nxt = '0;
                    w_runs_q_nxt  = num_runs;
                end else begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count   = r_count;
        run_idx = r_run_idx;
        busy    = (r_state == S_RUN) || (r_state == S_PAUSE);
        done    = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed vector table plus hand-written DONE-restart and mid-pause reset sequences for counter_run_ctrl.
module tb_counter_run_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] num_runs;
    logic       pause;
    logic       abort;
    logic [1:0] count;
    logic [3:0] run_idx;
    logic       busy;
    logic       done;

    int vec_cnt;
    int err_cnt;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] num_runs;
        logic       pause;
        logic       abort;
        logic [1:0] exp_count;
        logic [3:0] exp_idx;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t tbl[$];

    counter_run_ctrl #(.WIDTH(2), .RUNS_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_runs (num_runs),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .run_idx  (run_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] n,
                                input logic p, input logic a, input logic [1:0] c,
                                input logic [3:0] i, input logic b, input logic d);
        vec_t v;
        v.rst = r; v.start = s; v.num_runs = n; v.pause = p; v.abort = a;
        v.exp_count = c; v.exp_idx = i; v.exp_busy = b; v.exp_done = d;
        return v;
    endfunction

    task automatic step(input logic r, input logic s, input logic [3:0] n,
                        input logic p, input logic a);
        @(negedge clk);
        rst = r; start = s; num_runs = n; pause = p; abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] c, input logic [3:0] i,
                         input logic b, input logic d);
        vec_cnt++;
        if ({count, run_idx, busy, done} !== {c, i, b, d}) begin
            err_cnt++;
            $display("FAIL %s: got count=%0d run_idx=%0d busy=%0b done=%0b, want count=%0d run_idx=%0d busy=%0b done=%0b",
                     name, count, run_idx, busy, done, c, i, b, d);
        end
    endtask

    initial begin
        int edges;
        bit seen;
        vec_cnt = 0; err_cnt = 0;
        rst = 1'b1; start = 1'b0; num_runs = '0; pause = 1'b0; abort = 1'b0;

        // reset dominates start
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0));
        // two-pass job
        tbl.push_back(mk(0,1,1,0,0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 3,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,0));
        // single pass with pause at count 2 (resume edge does not count)
        tbl.push_back(mk(0,1,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 3,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // abort from RUN
        tbl.push_back(mk(0,1,2,0,0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // abort beats pause from PAUSE
        tbl.push_back(mk(0,1,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,1,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // start during RUN is ignored; job still ends after one pass
        tbl.push_back(mk(0,1,0,0,0, 0,0,1,0));
        tbl.push_back(mk(0,1,7,0,0, 1,0,1,0));
        tbl.push_back(mk(0,1,7,0,0, 2,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 3,0,1,0));
        tbl.push_back(mk(0,1,3,0,0, 0,0,0,1));

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].start, tbl[k].num_runs, tbl[k].pause, tbl[k].abort);
            check($sformatf("vec%0d", k), tbl[k].exp_count, tbl[k].exp_idx,
                  tbl[k].exp_busy, tbl[k].exp_done);
        end

        // start while in DONE
        step(0, 1, 1, 0, 0);
`ifdef AUTO_RESTART_EN
        check("done_start_restart", 0, 0, 1, 0);
`else
        check("done_start_ignored", 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("idle_start", 0, 0, 1, 0);
`endif
        edges = 0;
        seen = 0;
        for (int t = 1; t <= 20; t++) begin
            step(0, 0, 0, 0, 0);
            if (done) begin
                edges = t;
                seen = 1;
                break;
            end
        end
        vec_cnt++;
        if (!seen || edges != 8) begin
            err_cnt++;
            $display("FAIL job_latency: got %0d edges (seen=%0b), want 8", edges, seen);
        end
        check("latency_done_vals", 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        check("after_done_idle", 0, 1, 0, 0);

        // reset in the middle of a paused job
        step(0, 1, 3, 0, 0);
        for (int t = 0; t < 5; t++) step(0, 0, 0, 0, 0);
        check("mid_job", 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        check("paused", 1, 1, 1, 0);
        step(1, 0, 0, 1, 1);
        check("rst_in_pause", 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("post_rst%0d", t), 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
